// File: rtl/keypad_pkg.sv
// keypad_pkg: state encoding and the 4x4 key map shared by keypad emulator and scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
  // Indexed by key code; each entry is {col, row}, both active-low.
  localparam logic [7:0] KEY_MAP [16] = '{
    8'hEB, 8'h77, 8'h7B, 8'h7D, 8'hB7, 8'hBB, 8'hBD, 8'hD7,
    8'hDB, 8'hDD, 8'h7E, 8'hBE, 8'hDE, 8'hEE, 8'hED, 8'hE7
  };
  function automatic logic [7:0] key_to_matrix(input logic [3:0] code);
    return KEY_MAP[code];
  endfunction
  // Returns {hit, code}; hit=0 when {col,row} is not a single-key pattern.
  function automatic logic [4:0] matrix_to_key(input logic [3:0] col, input logic [3:0] row);
    logic [4:0] r;
    r = 5'h0;
    for (int i = 0; i < 16; i++)
      if (KEY_MAP[i] == {col, row}) r = {1'b1, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo: synchronous FIFO with flush
// Ports: clk/rst_n clock and async active-low reset; push/din write; pop/dout read
// (dout shows the head); flush empties; count/full/empty status.
module keypad_key_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;
  always_comb begin
    full    = count_q == (AW+1)'(DEPTH);
    empty   = count_q == '0;
    push_ok = push && !full && !flush;
    pop_ok  = pop && !empty && !flush;
    wr_d    = flush ? '0 : wr_q + AW'(push_ok);
    rd_d    = flush ? '0 : rd_q + AW'(pop_ok);
    count_d = flush ? '0 : count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    dout    = mem[rd_q];
    count   = count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_q] <= din;
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: replays queued key codes as timed presses on a 4x4 active-low matrix
// Ports: i_clk/i_rst_n clock and async active-low reset; col scanner column drive in;
// row lines out (4'hF = no key); key_code/key_valid/key_ready code stream in;
// flush aborts queue and press; pressing/active_key/key_done/fifo_count status.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int TICK_DIV    = 1048576,
  parameter int PRESS_TICKS = 8,
  parameter int GAP_TICKS   = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [3:0]                    col,
  output logic [3:0]                    row,
  input  logic [3:0]                    key_code,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic                          flush,
  output logic                          pressing,
  output logic [3:0]                    active_key,
  output logic                          key_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int TW = $clog2(TICK_DIV + 1);
  state_t        state_q, state_d;
  logic [TW-1:0] div_q, div_d;
  logic [7:0]    ticks_q, ticks_d, limit;
  logic [3:0]    active_key_q, active_key_d;
  logic [7:0]    matrix_q, matrix_d;
  logic [3:0]    fifo_dout;
  logic          fifo_full, fifo_empty, pop, tick, last;
  keypad_key_fifo #(.DEPTH(FIFO_DEPTH), .W(4)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (key_valid),
    .din   (key_code),
    .pop   (pop),
    .flush (flush),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_comb begin
    tick  = div_q == TW'(TICK_DIV - 1);
    limit = state_q == PRESS ? 8'(PRESS_TICKS - 1) : 8'(GAP_TICKS - 1);
    last  = tick && ticks_q == limit;
    pop   = state_q == IDLE && !fifo_empty && !flush;
    state_d      = state_q;
    active_key_d = active_key_q;
    matrix_d     = matrix_q;
    if (flush)
      state_d = IDLE;
    else if (pop) begin
      state_d      = PRESS;
      active_key_d = fifo_dout;
      matrix_d     = key_to_matrix(fifo_dout);
    end else if (state_q == PRESS && last)
      state_d = RELEASE;
    else if (state_q == RELEASE && last)
      state_d = IDLE;
    // Tick timing restarts on every state entry so each phase is exact.
    div_d   = (state_d != state_q || tick) ? '0 : div_q + TW'(1);
    ticks_d = state_d != state_q ? '0 : ticks_q + 8'(tick);
    key_ready  = !fifo_full;
    pressing   = state_q == PRESS;
    active_key = active_key_q;
    key_done   = state_q == RELEASE && last && !flush;
    // Any column combination that drives the key's column low closes the switch.
    row = (pressing && (col | matrix_q[7:4]) != 4'hF) ? matrix_q[3:0] : 4'hF;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      ticks_q      <= '0;
      active_key_q <= '0;
      matrix_q     <= 8'hFF;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      ticks_q      <= ticks_d;
      active_key_q <= active_key_d;
      matrix_q     <= matrix_d;
    end
endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Drives the row lines of a 4x4 active-low matrix keypad in response to the column drive from the keypad scanner, i.e. the keypad side of the scan interface.
- Accepts logical key codes (0x0-0xF) over a valid/ready stream, queues them, and replays each as a timed press/release on the matrix.
- Used as a bench/stimulus block and as a soft-keypad source on boards with no physical keypad.

Parameters:
- TICK_DIV, 1048576, i_clk cycles per timing tick; equals one scanner scan step (2^20 cycles).
- PRESS_TICKS, 8, ticks the key is held down; range 1-255.
- GAP_TICKS, 8, ticks of release before the next key; range 1-255.
- FIFO_DEPTH, 4, key-code queue entries; power of two, 2-16.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- col  in  4  column drive from the scanner, active-low.
- row  out  4  row lines to the scanner, active-low, 4'hF = no key.
- key_code  in  4  logical key to press.
- key_valid  in  1  key_code valid.
- key_ready  out  1  queue can accept.
- flush  in  1  synchronous abort: empty the queue and release the key.
- pressing  out  1  a key is currently held.
- active_key  out  4  code of the held/most recent key.
- key_done  out  1  one-cycle pulse when a key's release gap completes.
- fifo_count  out  clog2(FIFO_DEPTH)+1  queued entries.

Behaviour:
- Reset values: row=4'hF, key_ready=1, pressing=0, active_key=0, key_done=0, fifo_count=0, state=IDLE, queue empty.
- Only i_clk is used. The reset is asynchronous assert and synchronous-safe deassert.
- Key map from code to {col pattern, row pattern}, both active-low:
  - A=0111_1110, D=1110_1110, E=1110_1101, 0=1110_1011
  - C=1101_1110, 9=1101_1101, 8=1101_1011, B=1011_1110
  - 6=1011_1101, 5=1011_1011, F=1110_0111, 7=1101_0111
  - 4=1011_0111, 1=0111_0111, 2=0111_1011, 3=0111_1101
- Row drive is combinational from col and registered state:
  - In PRESS, row = key_row when (col | key_col) != 4'hF, that is, when the key's column line is driven low. This includes col=4'h0.
  - Otherwise row = 4'hF.
  - No other row value is ever produced.
- Queue:
  - key_ready = (fifo_count != FIFO_DEPTH).
  - A push happens when key_valid && key_ready.
  - A pop happens only on the IDLE->PRESS transition.
  - Simultaneous push and pop leaves the count unchanged.
  - The queue is FIFO-ordered. A push while full is impossible by construction.
- Tick counter restarts at 0 on every state entry and emits a tick every TICK_DIV cycles.
- States:
  - IDLE: if the queue is non-empty, pop. Latch active_key, key_col and key_row. Go to PRESS next cycle. Otherwise stay.
  - PRESS: pressing=1. After PRESS_TICKS ticks (exactly PRESS_TICKS*TICK_DIV cycles), go to RELEASE.
  - RELEASE: pressing=0 and row=4'hF. After GAP_TICKS ticks, go to IDLE and assert key_done for 1 cycle on that transition.
- Latency: a push into an empty queue while in IDLE gives pressing=1 two cycles after the push edge.
- Back-to-back keys: the next pop happens on the cycle after key_done. The minimum IDLE dwell is 1 cycle.
- flush has priority over everything:
  - The queue empties and the next state is IDLE.
  - key_done is not pulsed and row returns to 4'hF on the next cycle.
  - active_key is retained.
  - A push in the same cycle as flush is discarded.
- Reset mid-PRESS forces row=4'hF immediately (asynchronous).

Decomposition:
- Package keypad_pkg holds:
  - the state encoding (IDLE, PRESS, RELEASE);
  - the 16-entry code -> {col,row} map as a constant function key_to_matrix();
  - the inverse map, which the scanner and other users share.
- Sub-module keypad_key_fifo is a parameterised synchronous FIFO with push, pop, flush, count, full and empty.

Test Plan:
- Use TICK_DIV=4, PRESS_TICKS=2, GAP_TICKS=2 unless noted.
- Reset check: after reset, row=F, key_ready=1, fifo_count=0. With col=0 and no key, row stays F.
- Single key 5: push 0x5 and sweep col through E, D, B, 7, 0. row=B only for col=B and col=0, otherwise F. pressing stays high exactly 8 cycles. key_done pulses once 8 cycles after the release starts.
- Ordering and full: push 1, 2, 3, A back to back. key_ready drops after the 4th push (or the 5th if one was already popped). Keys are replayed as 1, 2, 3, A. There are 4 key_done pulses and fifo_count ends at 0.
- Flush mid-press: push 9 and 4, then assert flush in the 3rd PRESS cycle. Next cycle row=F, state=IDLE, fifo_count=0. No key_done pulse, and key 4 is never pressed.
- Reset mid-press: assert i_rst_n low during PRESS of key F with col=E. row=F in the same cycle and all outputs return to reset values.
- Scanner loop: connect to the scanner with TICK_DIV=1048576, PRESS_TICKS=8 and push E. The scanner reports keyboard_val=E with valid=1, then valid=0 after release.
